// File: rtl/ddr4_status_monitor.sv
// rtl/ddr4_status_monitor.sv - DDR4 calibration sync, app-interface snoop and packed status word
// Optional read-hang watchdog and RD_HANG state: define DDR4_STATUS_RD_WATCHDOG_EN.
module ddr4_status_monitor #(
  parameter int          DDR4_STATUS_SIZE     = 32,
  parameter logic [31:0] CALIB_TIMEOUT_CYCLES = 32'd16777216,
  parameter logic [15:0] RD_WATCHDOG_CYCLES   = 16'd4096
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        calib_complete_async_i,
  input  logic                        app_en_i,
  input  logic                        app_rdy_i,
  input  logic [2:0]                  app_cmd_i,
  input  logic                        app_rd_data_valid_i,
  input  logic                        app_rd_data_end_i,
  output logic [DDR4_STATUS_SIZE-1:0] ddr4_status_o,
  output logic                        ddr4_init_calib_complete_o
);

  typedef enum logic [1:0] {
    ST_WAIT_CALIB = 2'd0,
    ST_RUN        = 2'd1,
    ST_CALIB_FAIL = 2'd2,
    ST_RD_HANG    = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_s1;
  logic        r_s2;
  logic        r_cto;
  logic        r_lost;
  logic        r_hang;
  logic        r_ovf;
  logic        r_unf;
  logic [7:0]  r_out;
  logic [15:0] r_done;
  logic [31:0] r_calib_cnt;

  logic w_rd_accept;
  logic w_rd_done;
  logic w_wd_expire;

  assign w_rd_accept = app_en_i & app_rdy_i & (app_cmd_i == 3'b001);
  assign w_rd_done   = app_rd_data_valid_i & app_rd_data_end_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= calib_complete_async_i;
      r_s2 <= r_s1;
    end
  end

`ifdef DDR4_STATUS_RD_WATCHDOG_EN
  logic [15:0] r_wd_cnt;

  assign w_wd_expire = (r_state == ST_RUN) && (r_out != 8'd0) && !w_rd_done &&
                       (r_wd_cnt == RD_WATCHDOG_CYCLES - 16'd1);

  // Holds its value outside RUN so a brief calibration dip does not hide a stuck read.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd_cnt <= 16'd0;
    end else if (w_rd_done || (r_out == 8'd0) || w_wd_expire) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == ST_RUN) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end
`else
  logic w_unused_wd_cfg;
  assign w_unused_wd_cfg = ^RD_WATCHDOG_CYCLES;
  assign w_wd_expire     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_out  <= 8'd0;
      r_done <= 16'd0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_rd_done) begin
        r_done <= r_done + 16'd1;
      end
      case ({w_rd_accept, w_rd_done})
        2'b10: begin
          if (r_out == 8'hFF) r_ovf <= 1'b1;
          else                r_out <= r_out + 8'd1;
        end
        2'b01: begin
          if (r_out == 8'd0) r_unf <= 1'b1;
          else               r_out <= r_out - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_WAIT_CALIB;
      r_calib_cnt <= 32'd0;
      r_cto       <= 1'b0;
      r_lost      <= 1'b0;
      r_hang      <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_CALIB: begin
          if (r_s2) begin
            r_state <= ST_RUN;
          end else if (r_calib_cnt == CALIB_TIMEOUT_CYCLES - 32'd1) begin
            r_state <= ST_CALIB_FAIL;
            r_cto   <= 1'b1;
          end else begin
            r_calib_cnt <= r_calib_cnt + 32'd1;
          end
        end
        ST_CALIB_FAIL: begin
          if (r_s2) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!r_s2) begin
            r_state     <= ST_WAIT_CALIB;
            r_lost      <= 1'b1;
            r_calib_cnt <= 32'd0;
          end else if (w_wd_expire) begin
            r_state <= ST_RD_HANG;
            r_hang  <= 1'b1;
          end
        end
        ST_RD_HANG: begin
          // Losing calibration outranks a late completion.
          if (!r_s2) begin
            r_state     <= ST_WAIT_CALIB;
            r_lost      <= 1'b1;
            r_calib_cnt <= 32'd0;
          end else if (w_rd_done) begin
            r_state <= ST_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    ddr4_status_o       = '0;
    ddr4_status_o[31:0] = {r_done, r_out, r_unf, r_ovf, r_hang, r_lost, r_cto, r_s2, r_state};
  end

  assign ddr4_init_calib_complete_o = r_s2;

endmodule

// File: doc/ddr4_status_monitor.md
# ddr4_status_monitor

Status collector that sits directly upstream of the DDR4 register file and produces its `ddr4_status_i` / `ddr4_init_calib_complete_i` inputs. It synchronises the DDR4 IP calibration flag into `clk_i` and snoops the controller app interface. A small FSM tracks link health. It maintains an outstanding-read count, a completion counter, a calibration timeout and a read-hang watchdog, and packs everything into one registered status word. All error flags are sticky until reset, because the register file exposes no write path.

## Interface
Parameters:
- `DDR4_STATUS_SIZE`, 32: status word width; must be ≥32; bits above 31 read 0.
- `CALIB_TIMEOUT_CYCLES`, 32'd16777216: cycles in WAIT_CALIB before the calibration timeout is declared; ≥2.
- `RD_WATCHDOG_CYCLES`, 16'd4096: cycles without a read completion, while reads are outstanding, before a hang is declared; ≥2.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `calib_complete_async_i` in 1: DDR4 IP init_calib_complete; asynchronous to `clk_i`.
- `app_en_i` in 1: controller command valid.
- `app_rdy_i` in 1: controller command ready.
- `app_cmd_i` in 3: command; 3'b001 = read, all other values are ignored.
- `app_rd_data_valid_i` in 1: read data beat valid.
- `app_rd_data_end_i` in 1: last beat of a read.
- `ddr4_status_o` out `DDR4_STATUS_SIZE`: packed status word.
- `ddr4_init_calib_complete_o` out 1: synchronised calibration flag.

## Operation
- **Calibration synchroniser:** two flops, s1 then s2. `ddr4_init_calib_complete_o` = s2.
- **Read accept:** `app_en_i & app_rdy_i & app_cmd_i==3'b001`.
- **Read completion:** `app_rd_data_valid_i & app_rd_data_end_i`.
- **Outstanding count (8 bit):**
  - +1 on accept, −1 on completion.
  - Accept and completion in the same cycle: value unchanged.
  - Accept only, at 255: value stays 255 and sticky OVF is set.
  - Completion only, at 0: value stays 0 and sticky UNF is set.
- **Completed-reads counter (16 bit):** +1 per completion; wraps 0xFFFF→0x0000.
- **FSM** (encoding in brackets):
  - WAIT_CALIB (0):
    - s2=1 → RUN.
    - Otherwise the calibration counter increments. On the cycle it equals `CALIB_TIMEOUT_CYCLES-1`: → CALIB_FAIL and sticky CTO set.
  - CALIB_FAIL (2): s2=1 → RUN; CTO stays set.
  - RUN (1):
    - s2=0 → WAIT_CALIB, sticky LOST set, calibration counter cleared to 0.
    - Watchdog expiry → RD_HANG, sticky HANG set.
  - RD_HANG (3):
    - Any completion → RUN.
    - s2=0 → WAIT_CALIB with LOST set; this has priority over completion.
- **Watchdog counter:**
  - Counts only in RUN, while outstanding>0 and no completion occurs in that cycle.
  - Cleared on a completion or when outstanding==0.
  - Expires on the cycle it equals `RD_WATCHDOG_CYCLES-1`.
- **Snoop gating:**
  - The counters snoop the app interface in every state.
  - The watchdog runs only in RUN.
- **Status packing:**
  - [1:0] state.
  - [2] s2.
  - [3] CTO, [4] LOST, [5] HANG, [6] OVF, [7] UNF.
  - [15:8] outstanding count.
  - [31:16] completed reads.
- **Reset behaviour:**
  - All flops clear to 0; state = WAIT_CALIB.
  - Both outputs are 0 during reset.
  - Reset mid-operation discards all counts and sticky flags immediately (asynchronous).

## Timing
- **Calibration flag latency:** input sampled high at edge N → s2=1 after edge N+1 → `ddr4_init_calib_complete_o`=1 after edge N+1.
- **State latency:** the state field reads RUN after edge N+2.
- **Status word path:** `ddr4_status_o` is a direct concatenation of registers with no extra stage. A counter event at edge N is visible after edge N.
- **Error-flag timing:** sticky flags and state transitions update on the same edge.
- **Handshake:** no backpressure is generated; the block is a pure observer. Snoop inputs are synchronous to `clk_i`.
- **Downstream latency:** the register file adds its own cycle of latency.

## Configuration
- Macro: `DDR4_STATUS_RD_WATCHDOG_EN`.
- Defined:
  - Watchdog counter and RD_HANG state are present, as described above.
- Undefined:
  - No watchdog logic.
  - The FSM never enters RD_HANG.
  - Status bit [5] is tied to 0.
  - `RD_WATCHDOG_CYCLES` is ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use `CALIB_TIMEOUT_CYCLES`=100 and `RD_WATCHDOG_CYCLES`=16.

- **Calibration rise:** release reset; raise calib at cycle 10.
  - `ddr4_init_calib_complete_o`=1 two edges later.
  - State=1 one edge after that.
  - Status=0x00000005.
- **Calibration timeout:** keep calib low.
  - After 100 cycles, state=2 and bit3=1.
  - Raise calib → state=1, bit3 still 1; status=0x0000000D.
- **Outstanding count:** in RUN, accept 3 reads, then 1 accept + 1 completion in the same cycle, then 3 completions.
  - Outstanding goes 3 → 3 → 0.
  - Completed-reads field = 4.
  - No OVF/UNF.
- **Read hang (macro defined):** 1 read accepted, no completion.
  - Exactly 16 cycles later, state=3 and bit5=1.
  - One completion → state=1, bit5 still 1, outstanding=0.
- **Counter boundaries:**
  - 256 accepts with no completions → outstanding=255, bit6=1.
  - Completion with outstanding=0 → bit7=1, outstanding stays 0.
  - Drive 65537 completions → field wraps to 0x0001.
- **Calibration loss and reset:** drop calib in RUN → state=0, bit4=1. Then assert `reset_n_i` mid-burst → both outputs 0 immediately.
